weight_update_sequencer: RTL
============================

WEIGHT_UPDATE_SEQUENCER -- requirements
Module: weight_update_sequencer

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- LAYER_NUM  4  maximum layers sequenced
- LAYER_ADDR_WIDTH  2  width of layer index, >= clog2(LAYER_NUM)
- NEURON_NUM  5  vector length per layer
- ACTIVATION_WIDTH  8  width of each a/delta element
- WEIGHT_WIDTH  16  width of each stored weight
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a sweep; sampled only in IDLE
- layer_count  in  LAYER_ADDR_WIDTH+1  layers to process; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sweep end
- sat_flag  out  1  sticky: a saturation occurred this sweep
- rd_req  out  1  layer-parameter read request
- rd_addr  out  LAYER_ADDR_WIDTH  layer index being read
- rd_ack  in  1  read data valid; completes rd_req
- rd_a  in  NEURON_NUM*ACTIVATION_WIDTH  activations
- rd_delta  in  NEURON_NUM*ACTIVATION_WIDTH  deltas
- rd_w  in  NEURON_NUM*NEURON_NUM*WEIGHT_WIDTH  current weights
- upd_start  out  1  one-cycle start pulse to the weight updater
- upd_a, upd_delta, upd_w  out  widths as rd_a/rd_delta/rd_w  registered operands
- upd_result  in  NEURON_NUM*NEURON_NUM*(WEIGHT_WIDTH+1)  updater result
- upd_finish  in  1  updater completion pulse
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  LAYER_ADDR_WIDTH  layer written back
- wr_data  out  NEURON_NUM*NEURON_NUM*WEIGHT_WIDTH  narrowed weights

Function
REQ-003 States SHALL be IDLE, FETCH, START, WAIT, WRITE, DONE.
REQ-004 IDLE: start=1 SHALL latch n=min(layer_count,LAYER_NUM) and go to DONE if n=0, else set addr=n-1 and go to FETCH.
REQ-005 FETCH SHALL hold rd_req=1 and rd_addr=addr until rd_ack=1; that cycle SHALL latch rd_a/rd_delta/rd_w into upd_* and go to START.
REQ-006 START SHALL assert upd_start for exactly one cycle, then go to WAIT.
REQ-007 WAIT SHALL wait unbounded for upd_finish; that cycle SHALL latch narrowed upd_result into wr_data and go to WRITE.
REQ-008 WRITE SHALL assert wr_en for one cycle with wr_addr=addr; if addr=0 go to DONE, else decrement addr and go to FETCH.
REQ-009 Layers SHALL be processed in descending order, n-1 down to 0.
REQ-010 DONE SHALL assert done for one cycle and return to IDLE; busy SHALL be low the cycle after done.
REQ-011 start outside IDLE SHALL be ignored; upd_finish outside WAIT and rd_ack outside FETCH SHALL be ignored.
REQ-012 Minimum per-layer latency SHALL be 4 cycles plus rd_ack and upd_finish wait times.
REQ-013 sat_flag SHALL clear on an accepted start and hold until the next accepted start.

Reset
REQ-014 With rst=1, state SHALL be IDLE, and busy, done, rd_req, upd_start, wr_en, sat_flag, addr, upd_* and wr_data SHALL be 0. This holds mid-sweep; the sweep is abandoned without any write.

Configuration
REQ-015 With WEIGHT_SAT_EN defined, each signed (WEIGHT_WIDTH+1)-bit result element SHALL clamp to [-2^(WEIGHT_WIDTH-1), 2^(WEIGHT_WIDTH-1)-1]; any clamp SHALL set sat_flag.
REQ-016 Without WEIGHT_SAT_EN, each element SHALL keep its low WEIGHT_WIDTH bits and sat_flag SHALL be constant 0.

Structure
REQ-017 Package weight_update_pkg SHALL hold the state enum and the saturation min/max constant functions.
REQ-018 Per-element narrowing SHALL be sub-module weight_narrow (one element, macro-controlled), instantiated NEURON_NUM*NEURON_NUM times.

Verification
REQ-019 layer_count=3, rd_ack and upd_finish each delayed 2 cycles -> reads 2,1,0 in order, three wr_en pulses, one done, busy low afterward.
REQ-020 layer_count=0 -> done the cycle after DONE is entered; no rd_req, upd_start or wr_en.
REQ-021 layer_count=7 with LAYER_NUM=4 -> exactly 4 layers processed, addresses 3..0.
REQ-022 WEIGHT_SAT_EN, one result element 17'h0_9000 (+36864) -> wr_data element 16'h7FFF and sat_flag=1; 17'h1_7000 -> 16'h8000. Without the macro: 16'h9000 and 16'h7000, sat_flag=0.
REQ-023 rst pulsed during WAIT of layer 1 -> all outputs 0, no wr_en; a later start with layer_count=1 completes normally.
REQ-024 start pulsed while busy, stray upd_finish in FETCH -> no effect on sequence or outputs.

Source files
------------

// File: rtl/weight_update_pkg.sv
// Shared FSM state encoding and weight saturation limits for the weight
// update sequencer and its per-element narrowing stage.
package weight_update_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Largest signed value representable in a width-bit weight.
  function automatic logic signed [31:0] sat_max(input int unsigned width);
    sat_max = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] sat_min(input int unsigned width);
    sat_min = -(32'sd1 <<< (width - 32'd1));
  endfunction

endpackage

// File: rtl/weight_narrow.sv
// Narrows one signed (WEIGHT_WIDTH+1)-bit updater result to WEIGHT_WIDTH bits.
// WEIGHT_SAT_EN: clamp to the signed weight range and flag it; otherwise truncate.
module weight_narrow
  import weight_update_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 16
) (
  input  logic [WEIGHT_WIDTH:0]   res_i,
  output logic [WEIGHT_WIDTH-1:0] w_o,
  output logic                    sat_o
);

`ifdef WEIGHT_SAT_EN
  localparam logic signed [31:0] SAT_MAX = sat_max(WEIGHT_WIDTH);
  localparam logic signed [31:0] SAT_MIN = sat_min(WEIGHT_WIDTH);

  logic signed [31:0] res_ext_s;

  assign res_ext_s = {{(31 - WEIGHT_WIDTH){res_i[WEIGHT_WIDTH]}}, res_i};

  // Clamp out-of-range results to the nearest representable weight.
  always_comb begin
    if (res_ext_s > SAT_MAX) begin
      w_o   = SAT_MAX[WEIGHT_WIDTH-1:0];
      sat_o = 1'b1;
    end else if (res_ext_s < SAT_MIN) begin
      w_o   = SAT_MIN[WEIGHT_WIDTH-1:0];
      sat_o = 1'b1;
    end else begin
      w_o   = res_i[WEIGHT_WIDTH-1:0];
      sat_o = 1'b0;
    end
  end
`else
  logic unused_sign_s;

  assign unused_sign_s = res_i[WEIGHT_WIDTH];
  assign w_o           = res_i[WEIGHT_WIDTH-1:0];
  assign sat_o         = 1'b0;
`endif

endmodule

// File: rtl/weight_update_sequencer.sv
// Walks layers n-1..0: fetch operands, pulse the updater, wait, write back.
// WEIGHT_SAT_EN selects clamped write-back with a sticky sat_flag.
module weight_update_sequencer
  import weight_update_pkg::*;
#(
  parameter int LAYER_NUM        = 4,
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int NEURON_NUM       = 5,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int WEIGHT_WIDTH     = 16
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    start,
  input  logic [LAYER_ADDR_WIDTH:0]                               layer_count,
  output logic                                                    busy,
  output logic                                                    done,
  output logic                                                    sat_flag,
  output logic                                                    rd_req,
  output logic [LAYER_ADDR_WIDTH-1:0]                             rd_addr,
  input  logic                                                    rd_ack,
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]                  rd_a,
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]                  rd_delta,
  input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_WIDTH-1:0]           rd_w,
  output logic                                                    upd_start,
  output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]                  upd_a,
  output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]                  upd_delta,
  output logic [NEURON_NUM*NEURON_NUM*WEIGHT_WIDTH-1:0]           upd_w,
  input  logic [NEURON_NUM*NEURON_NUM*(WEIGHT_WIDTH+1)-1:0]       upd_result,
  input  logic                                                    upd_finish,
  output logic                                                    wr_en,
  output logic [LAYER_ADDR_WIDTH-1:0]                             wr_addr,
  output logic [NEURON_NUM*NEURON_NUM*WEIGHT_WIDTH-1:0]           wr_data
);

  localparam int A_W   = NEURON_NUM * ACTIVATION_WIDTH;
  localparam int ELEMS = NEURON_NUM * NEURON_NUM;
  localparam int W_W   = ELEMS * WEIGHT_WIDTH;
  localparam logic [LAYER_ADDR_WIDTH:0] LAYER_NUM_C = (LAYER_ADDR_WIDTH + 1)'(LAYER_NUM);

  state_e                      state_q, state_d;
  logic [LAYER_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                        sat_flag_q, sat_flag_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        rd_req_q, rd_req_d;
  logic                        upd_start_q, upd_start_d;
  logic                        wr_en_q, wr_en_d;
  logic [A_W-1:0]              upd_a_q, upd_a_d;
  logic [A_W-1:0]              upd_delta_q, upd_delta_d;
  logic [W_W-1:0]              upd_w_q, upd_w_d;
  logic [W_W-1:0]              wr_data_q, wr_data_d;
  logic [LAYER_ADDR_WIDTH:0]   n_s;
  logic [W_W-1:0]              narrow_s;
  logic [ELEMS-1:0]            sat_s;

  assign n_s = (layer_count > LAYER_NUM_C) ? LAYER_NUM_C : layer_count;

  for (genvar i = 0; i < ELEMS; i++) begin : g_narrow
    weight_narrow #(
      .WEIGHT_WIDTH(WEIGHT_WIDTH)
    ) u_narrow (
      .res_i(upd_result[i*(WEIGHT_WIDTH+1) +: WEIGHT_WIDTH+1]),
      .w_o  (narrow_s[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .sat_o(sat_s[i])
    );
  end

  // Next-state and datapath; strobes are decoded from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sat_flag_d  = sat_flag_q;
    upd_a_d     = upd_a_q;
    upd_delta_d = upd_delta_q;
    upd_w_d     = upd_w_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sat_flag_d = 1'b0;
          if (n_s == {(LAYER_ADDR_WIDTH + 1){1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = LAYER_ADDR_WIDTH'(n_s - (LAYER_ADDR_WIDTH + 1)'(1'b1));
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (rd_ack) begin
          upd_a_d     = rd_a;
          upd_delta_d = rd_delta;
          upd_w_d     = rd_w;
          state_d     = ST_START;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (upd_finish) begin
          wr_data_d  = narrow_s;
          sat_flag_d = sat_flag_q | (|sat_s);
          state_d    = ST_WRITE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (addr_q == {LAYER_ADDR_WIDTH{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q - LAYER_ADDR_WIDTH'(1'b1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    rd_req_d    = (state_d == ST_FETCH);
    upd_start_d = (state_d == ST_START);
    wr_en_d     = (state_d == ST_WRITE);
  end

  // State and output registers; reset abandons any sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= {LAYER_ADDR_WIDTH{1'b0}};
      sat_flag_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      upd_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      upd_a_q     <= {A_W{1'b0}};
      upd_delta_q <= {A_W{1'b0}};
      upd_w_q     <= {W_W{1'b0}};
      wr_data_q   <= {W_W{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sat_flag_q  <= sat_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_req_q    <= rd_req_d;
      upd_start_q <= upd_start_d;
      wr_en_q     <= wr_en_d;
      upd_a_q     <= upd_a_d;
      upd_delta_q <= upd_delta_d;
      upd_w_q     <= upd_w_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_flag  = sat_flag_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = addr_q;
  assign upd_start = upd_start_q;
  assign upd_a     = upd_a_q;
  assign upd_delta = upd_delta_q;
  assign upd_w     = upd_w_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = addr_q;
  assign wr_data   = wr_data_q;

endmodule
